// File: rtl/inta_sequencer.sv
// CPU-side 8259A interrupt-acknowledge initiator: synchronises INT, issues the two
// 8086-mode INTA pulses, captures the vector on pulse 2 and offers it over valid/ready.
module inta_sequencer #(
  parameter int PULSE_CYCLES = 2,
  parameter int GAP_CYCLES   = 2,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       int_in,
  input  logic       int_enable,
  input  logic [7:0] data_in,
  output logic       inta_n,
  output logic       pulse_idx,
  output logic       busy,
  output logic [7:0] vec_data,
  output logic       vec_valid,
  input  logic       vec_ready,
  output logic       spurious
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_P1,
    S_GAP,
    S_P2,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [3:0]             r_cnt;
  logic [3:0]             w_cnt_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_int_s;
  logic                   w_capture;
  logic                   w_spurious;

  logic                   r_inta_n;
  logic                   r_pulse_idx;
  logic                   r_busy;
  logic [7:0]             r_vec_data;
  logic                   r_vec_valid;
  logic                   r_spurious;

  assign w_int_s = r_sync[SYNC_STAGES-1];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], int_in};
    end
  end

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_capture  = 1'b0;
    w_spurious = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_int_s && int_enable && !r_vec_valid) w_next = S_ARM;
      end
      S_ARM: begin
        if (w_int_s) begin
          w_next     = S_P1;
          w_cnt_next = 4'(PULSE_CYCLES - 1);
        end else begin
          w_next     = S_IDLE;
          w_spurious = 1'b1;
        end
      end
      S_P1: begin
        if (r_cnt == 4'd0) begin
          w_next     = S_GAP;
          w_cnt_next = 4'(GAP_CYCLES - 1);
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_GAP: begin
        if (r_cnt == 4'd0) begin
          w_next     = S_P2;
          w_cnt_next = 4'(PULSE_CYCLES - 1);
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_P2: begin
        if (r_cnt == 4'd0) begin
          w_next    = S_DONE;
          w_capture = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so inta_n is a clean flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_inta_n    <= 1'b1;
      r_pulse_idx <= 1'b0;
      r_busy      <= 1'b0;
      r_spurious  <= 1'b0;
      r_vec_data  <= 8'h00;
      r_vec_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_cnt       <= w_cnt_next;
      r_inta_n    <= !((w_next == S_P1) || (w_next == S_P2));
      r_pulse_idx <= (w_next == S_P2) || (w_next == S_DONE);
      r_busy      <= (w_next != S_IDLE);
      r_spurious  <= w_spurious;
      if (w_capture) begin
        r_vec_data  <= data_in;
        r_vec_valid <= 1'b1;
      end else if (r_vec_valid && vec_ready) begin
        r_vec_valid <= 1'b0;
      end
    end
  end

  assign inta_n    = r_inta_n;
  assign pulse_idx = r_pulse_idx;
  assign busy      = r_busy;
  assign vec_data  = r_vec_data;
  assign vec_valid = r_vec_valid;
  assign spurious  = r_spurious;

endmodule

// File: tb/tb_inta_sequencer.sv
// Directed bench for inta_sequencer: per-cycle waveforms are recorded as bit strings
// (oldest sample in the MSB) and compared against hand-derived patterns.
module tb_inta_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       int_in;
  logic       int_enable;
  logic [7:0] data_in;
  logic       inta_n;
  logic       pulse_idx;
  logic       busy;
  logic [7:0] vec_data;
  logic       vec_valid;
  logic       vec_ready;
  logic       spurious;

  int n_tests = 0;
  int n_fail  = 0;

  inta_sequencer #(
    .PULSE_CYCLES(2),
    .GAP_CYCLES  (2),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .int_in    (int_in),
    .int_enable(int_enable),
    .data_in   (data_in),
    .inta_n    (inta_n),
    .pulse_idx (pulse_idx),
    .busy      (busy),
    .vec_data  (vec_data),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .spurious  (spurious)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Samples n cycles; optionally drops int_in right after sample index drop_at.
  task automatic record(input int n, input int drop_at,
                        output logic [15:0] o_inta, output logic [15:0] o_busy,
                        output logic [15:0] o_pidx, output logic [15:0] o_vv,
                        output logic [15:0] o_spur);
    o_inta = '0; o_busy = '0; o_pidx = '0; o_vv = '0; o_spur = '0;
    for (int i = 0; i < n; i++) begin
      tick();
      o_inta = {o_inta[14:0], inta_n};
      o_busy = {o_busy[14:0], busy};
      o_pidx = {o_pidx[14:0], pulse_idx};
      o_vv   = {o_vv[14:0], vec_valid};
      o_spur = {o_spur[14:0], spurious};
      if (i == drop_at) int_in = 1'b0;
    end
  endtask

  logic [15:0] w_inta, w_busy, w_pidx, w_vv, w_spur;
  logic        any_low, any_busy, all_valid;

  initial begin
    reset_n    = 1'b0;
    int_in     = 1'b0;
    int_enable = 1'b1;
    data_in    = 8'h00;
    vec_ready  = 1'b1;
    repeat (3) tick();
    check("rst_inta_n", 16'(inta_n), 16'h1);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_pidx", 16'(pulse_idx), 16'h0);
    check("rst_vec", {vec_data, 7'b0, vec_valid}, 16'h0000);
    check("rst_spur", 16'(spurious), 16'h0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Basic sequence: latency 4, low 2 / high 2 / low 2, vector held for one cycle.
    data_in = 8'h4D;
    int_in  = 1'b1;
    record(11, 3, w_inta, w_busy, w_pidx, w_vv, w_spur);
    check("t1_inta", w_inta, 16'b11100110011);
    check("t1_busy", w_busy, 16'b00111111110);
    check("t1_pidx", w_pidx, 16'b00000001110);
    check("t1_vv",   w_vv,   16'b00000000010);
    check("t1_vec",  16'(vec_data), 16'h4D);
    repeat (4) tick();

    // INT visible to the FSM for one cycle only: ARM aborts as spurious.
    int_in = 1'b1;
    record(6, 0, w_inta, w_busy, w_pidx, w_vv, w_spur);
    check("t2_spur", w_spur, 16'b000100);
    check("t2_inta", w_inta, 16'b111111);
    check("t2_busy", w_busy, 16'b001000);
    check("t2_vv",   w_vv,   16'b000000);
    repeat (4) tick();

    // Interrupts disabled: nothing happens; enabling starts ARM then P1.
    int_enable = 1'b0;
    int_in     = 1'b1;
    data_in    = 8'h91;
    any_low    = 1'b0;
    any_busy   = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      any_low  = any_low | !inta_n;
      any_busy = any_busy | busy;
    end
    check("t3_dis_inta", 16'(any_low), 16'h0);
    check("t3_dis_busy", 16'(any_busy), 16'h0);
    int_enable = 1'b1;
    record(10, 2, w_inta, w_busy, w_pidx, w_vv, w_spur);
    check("t3_inta", w_inta, 16'b1001100111);
    check("t3_vv",   w_vv,   16'b0000000100);
    check("t3_vec",  16'(vec_data), 16'h91);
    repeat (4) tick();

    // Consumer stalls: vector held, no second sequence until it is taken.
    vec_ready = 1'b0;
    data_in   = 8'hA5;
    int_in    = 1'b1;
    record(10, -1, w_inta, w_busy, w_pidx, w_vv, w_spur);
    check("t4a_inta", w_inta, 16'b1110011001);
    check("t4a_vv",   w_vv,   16'b0000000001);
    any_low   = 1'b0;
    any_busy  = 1'b0;
    all_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      any_low   = any_low | !inta_n;
      any_busy  = any_busy | busy;
      all_valid = all_valid & vec_valid;
    end
    check("t4_hold_inta", 16'(any_low), 16'h0);
    check("t4_hold_busy", 16'(any_busy), 16'h0);
    check("t4_hold_vv",   16'(all_valid), 16'h1);
    check("t4_hold_vec",  16'(vec_data), 16'hA5);
    data_in   = 8'h3C;
    vec_ready = 1'b1;
    record(10, 3, w_inta, w_busy, w_pidx, w_vv, w_spur);
    check("t4b_inta", w_inta, 16'b1100110011);
    check("t4b_vv",   w_vv,   16'b0000000010);
    check("t4b_vec",  16'(vec_data), 16'h3C);
    repeat (4) tick();

    // INT drops during GAP: the second pulse and capture still happen.
    data_in = 8'h08;
    int_in  = 1'b1;
    record(11, 5, w_inta, w_busy, w_pidx, w_vv, w_spur);
    check("t5_inta", w_inta, 16'b11100110011);
    check("t5_pidx", w_pidx, 16'b00000001110);
    check("t5_vec",  16'(vec_data), 16'h08);
    repeat (4) tick();

    // Reset during P2 takes effect immediately and discards the vector.
    data_in = 8'h77;
    int_in  = 1'b1;
    record(8, -1, w_inta, w_busy, w_pidx, w_vv, w_spur);
    check("t6_pre_inta", w_inta, 16'b11100110);
    #1 reset_n = 1'b0;
    #1;
    check("t6_rst_inta", 16'(inta_n), 16'h1);
    check("t6_rst_busy", 16'(busy), 16'h0);
    check("t6_rst_vec",  {vec_data, 7'b0, vec_valid}, 16'h0000);
    int_in = 1'b0;
    repeat (2) tick();
    reset_n  = 1'b1;
    any_low  = 1'b0;
    any_busy = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      any_low  = any_low | !inta_n;
      any_busy = any_busy | busy;
    end
    check("t6_post_inta", 16'(any_low), 16'h0);
    check("t6_post_busy", 16'(any_busy), 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
